broadcast_sequencer: RTL

BROADCAST_SEQUENCER -- requirements
Module: broadcast_sequencer

---
 rtl/bcast_pkg.sv | 22 ++
 rtl/ramp_tick_gen.sv | 23 ++
 rtl/broadcast_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/bcast_pkg.sv
// Shared state encoding, parameter defaults and small helpers for the
// broadcast on-air sequencer.
package bcast_pkg;

  localparam int RAMP_DIV_DEF  = 1250;
  localparam int RAMP_STEP_DEF = 16;
  localparam int AMP_W_DEF     = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_ON_AIR    = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  // States in which the carrier is gated on and the watchdog armed.
  function automatic logic is_active(state_e s);
    return (s == ST_RAMP_UP) || (s == ST_ON_AIR) || (s == ST_RAMP_DOWN);
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running prescaler; tick is high for one cycle every RAMP_DIV cycles,
// restarted from zero by clr.
module ramp_tick_gen #(
  parameter int RAMP_DIV = 1250
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(RAMP_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rstn || clr || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/broadcast_sequencer.sv
// Transmitter on/off sequencer: ramps carrier amplitude up and down on a
// slow tick and kills RF immediately on a watchdog timeout.
module broadcast_sequencer
  import bcast_pkg::*;
#(
  parameter int RAMP_DIV  = RAMP_DIV_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF,
  parameter int AMP_W     = AMP_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_req,
  input  logic             stop_req,
  input  logic [AMP_W-1:0] target_amp,
  input  logic             wd_triggered,
  input  logic             wd_warning,
  input  logic             fault_clear,
  output logic             wd_enable,
  output logic             rf_enable,
  output logic [AMP_W-1:0] amp_out,
  output logic [2:0]       state_o,
  output logic             fault_latched,
  output logic             warn_o
);

  localparam logic [AMP_W:0]   STEP_X = (AMP_W+1)'(RAMP_STEP);
  localparam logic [AMP_W-1:0] STEP_N = AMP_W'(RAMP_STEP);

  state_e           state_q, state_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic             tick;

  ramp_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state_d != state_q),
    .tick (tick)
  );

  // Slew candidates, evaluated one bit wider so nothing wraps near full scale.
  logic [AMP_W:0]   up_sum;
  logic [AMP_W-1:0] amp_up, amp_dn_tgt, amp_dn_zero;

  assign up_sum      = {1'b0, amp_q} + STEP_X;
  assign amp_up      = (up_sum >= {1'b0, target_amp}) ? target_amp : up_sum[AMP_W-1:0];
  assign amp_dn_tgt  = (({1'b0, target_amp} + STEP_X) <= {1'b0, amp_q}) ? amp_q - STEP_N
                                                                        : target_amp;
  assign amp_dn_zero = (STEP_X <= {1'b0, amp_q}) ? amp_q - STEP_N : '0;

  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    case (state_q)
      ST_IDLE: if (start_req && !stop_req) state_d = ST_RAMP_UP;
      ST_RAMP_UP: begin
        if (tick) amp_d = amp_up;
        // Leave on the same edge the amplitude reaches target.
        if (wd_triggered)          state_d = ST_FAULT;
        else if (stop_req)         state_d = ST_RAMP_DOWN;
        else if (amp_d >= target_amp) state_d = ST_ON_AIR;
      end
      ST_ON_AIR: begin
        if (tick) amp_d = (amp_q < target_amp) ? amp_up : amp_dn_tgt;
        if (wd_triggered)  state_d = ST_FAULT;
        else if (stop_req) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (tick) amp_d = amp_dn_zero;
        if (wd_triggered)    state_d = ST_FAULT;
        else if (amp_q == '0) state_d = ST_IDLE;
      end
      ST_FAULT: if (fault_clear) state_d = ST_IDLE;
      default:  state_d = ST_FAULT;
    endcase
    // Carrier is hard-zeroed whenever we are off air; no ramp on a kill.
    if (state_d == ST_IDLE || state_d == ST_FAULT) amp_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      amp_q         <= '0;
      rf_enable     <= 1'b0;
      wd_enable     <= 1'b0;
      fault_latched <= 1'b0;
      warn_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      amp_q         <= amp_d;
      rf_enable     <= is_active(state_d);
      wd_enable     <= is_active(state_d);
      fault_latched <= (state_d == ST_FAULT);
      warn_o        <= wd_warning && (state_d == ST_RAMP_UP || state_d == ST_ON_AIR);
    end
  end

  assign amp_out = amp_q;
  assign state_o = state_q;

endmodule
